// File: rtl/fsm_run_issuer_pkg.sv
// Shared definitions for the run issuer: FSM state encoding, default count width
// and a constant clog2 helper used for pointer and counter sizing.
package fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam int CNT_W_DEFAULT = 7;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fsm_run_issuer_if.sv
// Job/worker/status bundle of the run issuer. The slave modport is the issuer,
// the master modport is the producer/worker environment around it.
interface fsm_run_issuer_if #(
    parameter int CNT_W  = 7,
    parameter int JOBS_W = 8,
    parameter int LVL_W  = 3
) ();
    logic              i_valid;
    logic [CNT_W-1:0]  i_num;
    logic              o_ready;
    logic              o_run;
    logic [CNT_W-1:0]  o_num_cnt;
    logic              i_idle;
    logic              i_done;
    logic              o_job_done;
    logic              o_busy;
    logic              o_err;
    logic              i_clr_err;
    logic [JOBS_W-1:0] o_job_cnt;
    logic [LVL_W-1:0]  o_level;

    modport slave (
        input  i_valid, i_num, i_idle, i_done, i_clr_err,
        output o_ready, o_run, o_num_cnt, o_job_done, o_busy, o_err, o_job_cnt, o_level
    );

    modport master (
        output i_valid, i_num, i_idle, i_done, i_clr_err,
        input  o_ready, o_run, o_num_cnt, o_job_done, o_busy, o_err, o_job_cnt, o_level
    );
endinterface

// File: rtl/fsm_run_issuer_fifo.sv
// Synchronous show-ahead job FIFO; dout always presents the head entry.
module run_job_fifo
    import fsm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7,
    localparam int AW   = clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // storage carries no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
endmodule

// File: rtl/fsm_run_issuer.sv
// Run/done initiator: queues count jobs, issues one at a time to the worker,
// and watches each job with a done-timeout that raises a sticky error.
module fsm_run_issuer
    import fsm_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 256,
    parameter int JOBS_W  = 8
) (
    input logic            clk,
    input logic            reset,
    fsm_run_issuer_if.slave bus
);
    localparam int LVL_W = clog2(DEPTH) + 1;
    localparam int WD_W  = clog2(TIMEOUT);

    state_t            state;
    logic [WD_W-1:0]   wdog;
    logic [CNT_W-1:0]  head;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              run;
    logic [CNT_W-1:0]  num_cnt;
    logic              job_done;
    logic              busy;
    logic              err;
    logic [JOBS_W-1:0] job_cnt;

    // ready does not anticipate a same-cycle pop, so a full FIFO always stalls the producer
    assign push = bus.i_valid && !full;
    assign pop  = (state == S_IDLE) && !empty && bus.i_idle;

    run_job_fifo #(.DEPTH(DEPTH), .WIDTH(CNT_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.i_num),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wdog     <= '0;
            run      <= 1'b0;
            num_cnt  <= '0;
            job_done <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            job_cnt  <= '0;
        end else begin
            run      <= 1'b0;
            job_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        num_cnt <= head;
                        run     <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (bus.i_done) begin
                        job_done <= 1'b1;
                        job_cnt  <= job_cnt + 1'b1;
                        state    <= S_DONE;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    if (bus.i_clr_err) begin
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready    = !full;
    assign bus.o_run      = run;
    assign bus.o_num_cnt  = num_cnt;
    assign bus.o_job_done = job_done;
    assign bus.o_busy     = busy;
    assign bus.o_err      = err;
    assign bus.o_job_cnt  = job_cnt;
    assign bus.o_level    = level;
endmodule

// File: doc/fsm_run_issuer.md
Name: fsm_run_issuer

Overview:
- Initiator side of the run/done counter-worker interface.
- Buffers count jobs from an upstream producer in a small FIFO.
- Issues each job to a single worker as a one-cycle run pulse plus a held count value, then waits for the worker's done before issuing the next job.
- Provides a done-timeout watchdog, a sticky error flag and a completed-job counter for status reporting.

Parameters:
- DEPTH, 4: job FIFO depth. Power of two, 2..16.
- CNT_W, 7: job count width. Matches the worker count port.
- TIMEOUT, 256: maximum cycles spent in S_WAIT before an error is declared. Must be ≥ 2^CNT_W.
- JOBS_W, 8: width of the completed-job counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream job offer.
- i_num  in  CNT_W  job count value, taken when i_valid && o_ready.
- o_ready  out  1  FIFO not full.
- o_run  out  1  one-cycle pulse to the worker's run input.
- o_num_cnt  out  CNT_W  registered job count to the worker, held stable from S_ISSUE through S_WAIT.
- i_idle  in  1  worker idle status.
- i_done  in  1  worker done status, one cycle.
- o_job_done  out  1  one-cycle pulse per completed job.
- o_busy  out  1  high in any state other than S_IDLE.
- o_err  out  1  sticky watchdog error.
- i_clr_err  in  1  clears o_err and returns the block to S_IDLE.
- o_job_cnt  out  JOBS_W  completed jobs, wraps modulo 2^JOBS_W.
- o_level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all state and outputs cleared.
  - State is S_IDLE.
  - FIFO is empty; o_ready=1 (combinational from empty FIFO).
  - o_run=0, o_num_cnt=0, o_job_done=0, o_busy=0, o_err=0, o_job_cnt=0, o_level=0.
- Reset mid-operation: abandons the in-flight job and flushes the FIFO.
- FIFO:
  - Push when i_valid && o_ready. Pop only on entry to S_ISSUE.
  - o_ready = !full and does not look ahead to a same-cycle pop. A push offered while full is ignored, and the producer holds it.
  - Push and pop in the same cycle: occupancy is unchanged and both take effect.
  - Read and write pointers wrap at DEPTH.
- States: S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR.
- S_IDLE:
  - Go to S_ISSUE when FIFO not empty && i_idle.
  - On that edge, load o_num_cnt from the FIFO head and pop.
- S_ISSUE:
  - o_run=1 for exactly this cycle.
  - Go to S_WAIT unconditionally; the watchdog is cleared to 0.
- S_WAIT:
  - If i_done, go to S_DONE; i_done has priority over the timeout in the same cycle.
  - Else, if the watchdog equals TIMEOUT-1, go to S_ERR.
  - Else increment the watchdog.
  - i_done seen in any other state is ignored.
- S_DONE:
  - o_job_done=1 for this cycle; o_job_cnt increments (wraps).
  - Go to S_IDLE.
- S_ERR:
  - o_err=1, and it stays set.
  - No issue occurs; the FIFO is retained and pushes are still accepted.
  - i_clr_err: o_err=0 and go to S_IDLE on the next edge.
  - i_clr_err in any other state has no effect.
- Latency:
  - Push accepted on edge k into an empty FIFO with the worker idle: the S_IDLE→S_ISSUE transition happens at edge k+1, so o_run is high from edge k+1 to edge k+2.
  - Back-to-back jobs: the next o_run comes no earlier than 2 cycles after o_job_done, because the block passes through S_IDLE and waits for i_idle.
- Count rules:
  - i_num=0 is forwarded unchanged. The worker treats it as 2^CNT_W counts, which is why TIMEOUT must be ≥ 2^CNT_W.
  - o_num_cnt changes only on the S_IDLE→S_ISSUE edge.

Decomposition:
- Shared package (fsm_pkg):
  - state encodings S_IDLE..S_ERR, 3 bits;
  - default CNT_W;
  - a clog2 function.
- One sub-module, run_job_fifo (synchronous FIFO):
  - parameters DEPTH and width;
  - ports push, pop, din, dout (head, show-ahead), full, empty, level.
- The FSM, watchdog and job counter live in fsm_run_issuer.

Test Plan:
- Single job: push i_num=5 at edge 0, worker model idle → o_run pulse between edges 1 and 2 with o_num_cnt=5; done at edge 7 → o_job_done pulse, o_job_cnt=1, state back in S_IDLE.
- Fill: push 4 jobs (3, 1, 7, 2) with the worker held busy (i_idle=0) → o_ready=0 and o_level=4; a 5th push is ignored; release the worker → jobs issue in order 3, 1, 7, 2 and o_job_cnt=4.
- Simultaneous push/pop: FIFO at level 2, push on the same edge as the S_ISSUE pop → o_level stays 2 and order is preserved.
- Timeout: TIMEOUT=256, the worker never asserts done → o_err=1 exactly 256 cycles after the o_run pulse; pushes are still accepted; i_clr_err → o_err=0, S_IDLE, and the next job issues.
- Done vs timeout tie: i_done arrives in the cycle the watchdog equals TIMEOUT-1 → S_DONE, o_err stays 0.
- Reset mid-job: assert reset during S_WAIT with 3 jobs queued → all outputs at reset values immediately, o_level=0; a later done pulse produces no o_job_done.
